// File: rtl/async_ram_pkg.sv
// Shared widths and state encoding for the asynchronous RAM bus master.
package async_ram_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        W_SETUP,
        W_PULSE,
        W_HOLD,
        READ
    } ram_master_state_t;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/async_ram_master.sv
// Clocked request/response master for a 16-bit asynchronous RAM with registered,
// programmable-length strobes and mutually exclusive data-bus drivers.
//
// state   | meaning
// IDLE    | o_ready high, waiting for a request
// W_SETUP | address/data driven, write strobe still high
// W_PULSE | write strobe low
// W_HOLD  | strobe released, address/data still driven
// READ    | RAM output transmitter enabled, waiting for access time
module async_ram_master
    import async_ram_pkg::*;
#(
    parameter int SETUP_CYCLES = 1,
    parameter int PULSE_CYCLES = 1,
    parameter int HOLD_CYCLES  = 1,
    parameter int READ_CYCLES  = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              o_ready,
    output logic              o_done,
    output logic              o_rvalid,
    output logic [DATA_W-1:0] o_rdata,
    output logic [ADDR_W-1:0] o_address,
    output logic              o_writeNEn,
    output logic [DATA_W-1:0] o_writeData,
    output logic              o_dataOe,
    output logic              o_noe,
    input  logic [DATA_W-1:0] i_readData
);

    localparam int MAX_P = max4(SETUP_CYCLES, PULSE_CYCLES, HOLD_CYCLES, READ_CYCLES);
    localparam int CNT_W = $clog2(MAX_P) + 1;

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] READ_LD  = CNT_W'(READ_CYCLES - 1);

    if (SETUP_CYCLES < 1 || PULSE_CYCLES < 1 || HOLD_CYCLES < 1 || READ_CYCLES < 1) begin : g_param_check
        $error("async_ram_master: all cycle-count parameters must be >= 1");
    end

    ram_master_state_t state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              done_q;
    logic              rvalid_q;
    logic [DATA_W-1:0] rdata_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              wen_n_q;
    logic              data_oe_q;
    logic              noe_q;

    // Every bus strobe is a flop; the counter holds remaining cycles minus one.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wen_n_q   <= 1'b1;
            data_oe_q <= 1'b0;
            noe_q     <= 1'b1;
        end else begin
            done_q   <= 1'b0;
            rvalid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_req) begin
                        addr_q  <= i_addr;
                        wdata_q <= i_wdata;
                        if (i_we) begin
                            state_q   <= W_SETUP;
                            cnt_q     <= SETUP_LD;
                            data_oe_q <= 1'b1;
                            noe_q     <= 1'b1;
                        end else begin
                            state_q   <= READ;
                            cnt_q     <= READ_LD;
                            data_oe_q <= 1'b0;
                            noe_q     <= 1'b0;
                        end
                    end
                end
                W_SETUP: begin
                    if (cnt_q == '0) begin
                        state_q <= W_PULSE;
                        cnt_q   <= PULSE_LD;
                        wen_n_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                W_PULSE: begin
                    if (cnt_q == '0) begin
                        state_q <= W_HOLD;
                        cnt_q   <= HOLD_LD;
                        wen_n_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                W_HOLD: begin
                    if (cnt_q == '0) begin
                        state_q   <= IDLE;
                        data_oe_q <= 1'b0;
                        done_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                READ: begin
                    if (cnt_q == '0) begin
                        state_q  <= IDLE;
                        rdata_q  <= i_readData;
                        noe_q    <= 1'b1;
                        rvalid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    wen_n_q   <= 1'b1;
                    data_oe_q <= 1'b0;
                    noe_q     <= 1'b1;
                end
            endcase
        end
    end

    assign o_ready     = (state_q == IDLE);
    assign o_done      = done_q;
    assign o_rvalid    = rvalid_q;
    assign o_rdata     = rdata_q;
    assign o_address   = addr_q;
    assign o_writeData = wdata_q;
    assign o_writeNEn  = wen_n_q;
    assign o_dataOe    = data_oe_q;
    assign o_noe       = noe_q;

endmodule

// File: tb/tb_async_ram_master.sv
// Bench for async_ram_master: a default-parameter instance with a RAM model and a
// stretched-timing instance whose RAM returns the inverted address.
module tb_async_ram_master;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, req, we, sel;
    logic [15:0] addr, wdata;
    logic        req1, req2;
    assign req1 = req & ~sel;
    assign req2 = req & sel;

    logic        ready1, done1, rvalid1, wen1, doe1, noe1;
    logic [15:0] rdata1, address1, wbus1, rd1;
    logic        ready2, done2, rvalid2, wen2, doe2, noe2;
    logic [15:0] rdata2, address2, wbus2, rd2;

    async_ram_master dut1 (
        .i_clk(clk), .i_rst(rst), .i_req(req1), .i_we(we), .i_addr(addr), .i_wdata(wdata),
        .o_ready(ready1), .o_done(done1), .o_rvalid(rvalid1), .o_rdata(rdata1),
        .o_address(address1), .o_writeNEn(wen1), .o_writeData(wbus1), .o_dataOe(doe1),
        .o_noe(noe1), .i_readData(rd1)
    );

    async_ram_master #(.SETUP_CYCLES(2), .PULSE_CYCLES(3), .HOLD_CYCLES(2), .READ_CYCLES(4)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_req(req2), .i_we(we), .i_addr(addr), .i_wdata(wdata),
        .o_ready(ready2), .o_done(done2), .o_rvalid(rvalid2), .o_rdata(rdata2),
        .o_address(address2), .o_writeNEn(wen2), .o_writeData(wbus2), .o_dataOe(doe2),
        .o_noe(noe2), .i_readData(rd2)
    );

    // RAM model: latches on the rising edge of the write strobe, drives only while enabled.
    logic [15:0] mem1 [0:255];
    always @(posedge wen1) mem1[address1[7:0]] <= wbus1;
    assign rd1 = noe1 ? 16'h0000 : mem1[address1[7:0]];
    assign rd2 = noe2 ? 16'h0000 : ~address2;

    logic        o_ready, o_wen, o_doe, o_noe, o_done, o_rvalid;
    logic [15:0] o_rdata, o_address, o_wbus;
    assign o_ready   = sel ? ready2   : ready1;
    assign o_wen     = sel ? wen2     : wen1;
    assign o_doe     = sel ? doe2     : doe1;
    assign o_noe     = sel ? noe2     : noe1;
    assign o_done    = sel ? done2    : done1;
    assign o_rvalid  = sel ? rvalid2  : rvalid1;
    assign o_rdata   = sel ? rdata2   : rdata1;
    assign o_address = sel ? address2 : address1;
    assign o_wbus    = sel ? wbus2    : wbus1;

    int n_cmp = 0;
    int n_err = 0;
    int viol  = 0;

    always @(negedge clk) begin
        if ((doe1 && !noe1) || (!wen1 && !noe1) || (doe2 && !noe2) || (!wen2 && !noe2))
            viol = viol + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drives one transaction from a negedge and checks every cycle up to the done/rvalid cycle.
    task automatic run_txn(input bit t_we, input logic [15:0] t_addr, input logic [15:0] t_wdata,
                           input logic [15:0] t_exp, input bit noise,
                           input int s, input int p, input int h, input int r);
        int L;
        bit e_ready, e_wen, e_doe, e_noe, e_done, e_rv;
        L = t_we ? (s + p + h) : r;
        check($sformatf("ready_before_%h", t_addr), {31'd0, o_ready}, 32'd1);
        req = 1'b1; we = t_we; addr = t_addr; wdata = t_wdata;
        @(posedge clk); #1;
        req = 1'b0;
        for (int c = 1; c <= L + 1; c++) begin
            @(negedge clk);
            e_ready = (c == L + 1);
            if (t_we) begin
                e_wen  = !(c >= s + 1 && c <= s + p);
                e_doe  = (c <= L);
                e_noe  = 1'b1;
                e_done = (c == L + 1);
                e_rv   = 1'b0;
            end else begin
                e_wen  = 1'b1;
                e_doe  = 1'b0;
                e_noe  = (c > L);
                e_done = 1'b0;
                e_rv   = (c == L + 1);
            end
            check($sformatf("ctl_%s_%h_c%0d(rdy,wen,oe,noe,done,rv)", t_we ? "wr" : "rd", t_addr, c),
                  {26'd0, o_ready, o_wen, o_doe, o_noe, o_done, o_rvalid},
                  {26'd0, e_ready, e_wen, e_doe, e_noe, e_done, e_rv});
            check($sformatf("bus_addr_data_%h_c%0d", t_addr, c), {o_address, o_wbus}, {t_addr, t_wdata});
            if (!t_we && c == L + 1)
                check($sformatf("rdata_%h", t_addr), {16'd0, o_rdata}, {16'd0, t_exp});
            if (noise && c < L) begin
                req = 1'b1; we = ~t_we; addr = 16'($urandom); wdata = 16'($urandom);
            end else begin
                req = 1'b0;
            end
        end
        if (t_we && !sel)
            check($sformatf("ram_%h", t_addr), {16'd0, mem1[t_addr[7:0]]}, {16'd0, t_wdata});
    endtask

    typedef struct {
        bit          we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
        bit          noise;
    } vec_t;

    vec_t vecs [9];
    int   dcnt;

    initial begin
        vecs[0] = '{1'b1, 16'h00A5, 16'h1234, 16'h0000, 1'b0};
        vecs[1] = '{1'b0, 16'h00A5, 16'h0000, 16'h1234, 1'b0};
        vecs[2] = '{1'b1, 16'h0010, 16'h5A5A, 16'h0000, 1'b1};
        vecs[3] = '{1'b1, 16'h0011, 16'hFFFF, 16'h0000, 1'b0};
        vecs[4] = '{1'b0, 16'h0010, 16'h1111, 16'h5A5A, 1'b1};
        vecs[5] = '{1'b0, 16'h0011, 16'h2222, 16'hFFFF, 1'b0};
        vecs[6] = '{1'b1, 16'h00FF, 16'h0000, 16'h0000, 1'b0};
        vecs[7] = '{1'b0, 16'h00FF, 16'h3333, 16'h0000, 1'b1};
        vecs[8] = '{1'b0, 16'h00A5, 16'h4444, 16'h1234, 1'b0};

        rst = 1'b1; req = 1'b0; we = 1'b0; sel = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ctl1(rdy,wen,oe,noe,done,rv)", {26'd0, ready1, wen1, doe1, noe1, done1, rvalid1}, 32'b110100);
        check("reset_bus1", {address1, wbus1}, 32'd0);
        check("reset_rdata1", {16'd0, rdata1}, 32'd0);
        check("reset_ctl2(rdy,wen,oe,noe,done,rv)", {26'd0, ready2, wen2, doe2, noe2, done2, rvalid2}, 32'b110100);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++)
            run_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].noise, 1, 1, 1, 2);

        // Back-to-back: request held high, read accepted in the o_done cycle.
        check("b2b_ready_before", {31'd0, ready1}, 32'd1);
        req = 1'b1; we = 1'b1; addr = 16'h0001; wdata = 16'hBEEF;
        @(posedge clk); #1;
        we = 1'b0; wdata = 16'h0BAD;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check($sformatf("b2b_busy_c%0d(rdy,done,wdata)", c), {15'd0, ready1, done1, wbus1}, {17'd0, 16'hBEEF});
        end
        @(negedge clk);
        check("b2b_done_c4(rdy,done)", {30'd0, ready1, done1}, 32'b11);
        @(posedge clk); #1;
        req = 1'b0;
        for (int c = 5; c <= 6; c++) begin
            @(negedge clk);
            check($sformatf("b2b_read_c%0d(wen,oe,noe)", c), {29'd0, wen1, doe1, noe1}, 32'b100);
        end
        @(negedge clk);
        check("b2b_rvalid_c7(rdy,noe,rv)", {29'd0, ready1, noe1, rvalid1}, 32'b111);
        check("b2b_rdata", {16'd0, rdata1}, {16'd0, 16'hBEEF});
        check("b2b_ram", {16'd0, mem1[1]}, {16'd0, 16'hBEEF});

        // Stretched timing on the second instance.
        sel = 1'b1; #1;
        run_txn(1'b1, 16'h0042, 16'h7777, 16'h0000, 1'b0, 2, 3, 2, 4);
        run_txn(1'b0, 16'h0042, 16'h0000, 16'hFFBD, 1'b0, 2, 3, 2, 4);
        run_txn(1'b0, 16'h1234, 16'h5555, 16'hEDCB, 1'b1, 2, 3, 2, 4);
        run_txn(1'b1, 16'h8001, 16'hCAFE, 16'h0000, 1'b1, 2, 3, 2, 4);
        sel = 1'b0; #1;

        // Reset during the write pulse.
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 16'h0077; wdata = 16'hAAAA;
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_pulse_active(wen)", {31'd0, wen1}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_after(rdy,wen,oe,noe,done,rv)", {26'd0, ready1, wen1, doe1, noe1, done1, rvalid1}, 32'b110100);
        check("rst_after_bus", {address1, wbus1}, 32'd0);
        rst = 1'b0;
        dcnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done1 || rvalid1 || !ready1) dcnt++;
        end
        check("rst_no_done", dcnt, 32'd0);

        run_txn(1'b0, 16'h00A5, 16'h0000, 16'h1234, 1'b0, 1, 1, 1, 2);

        check("bus_invariant_violations", viol, 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/async_ram_master.md
# async_ram_master

Synchronous bus master that drives the 16-bit asynchronous RAM port (address, active-low write enable, write data, active-low output enable, read data) from a clocked request/response interface. It sits between the CPU's memory-access stage and the RAM and its output transmitter. It produces glitch-free, registered strobes with programmable setup, pulse, hold and read-access cycle counts. It guarantees the write-data driver and the RAM output transmitter are never enabled at the same time.

## Interface
Parameters:
- SETUP_CYCLES, 1, cycles address/data are stable before the write strobe; must be ≥1
- PULSE_CYCLES, 1, cycles o_writeNEn is low; must be ≥1
- HOLD_CYCLES, 1, cycles address/data are held after the strobe rises; must be ≥1
- READ_CYCLES, 2, cycles o_noe is low before read data is sampled; must be ≥1

Ports (one clock; reset is synchronous and active-high):
- i_clk  in  1  clock; all state changes on the rising edge
- i_rst  in  1  synchronous active-high reset
- i_req  in  1  transaction request
- i_we  in  1  1 = write, 0 = read; sampled with i_req
- i_addr  in  16  transaction address
- i_wdata  in  16  write data
- o_ready  out  1  high only in IDLE; accept = i_req & o_ready at an edge
- o_done  out  1  one-cycle pulse when a write completes
- o_rvalid  out  1  one-cycle pulse when o_rdata holds new read data
- o_rdata  out  16  captured read data; holds until the next read capture
- o_address  out  16  RAM address
- o_writeNEn  out  1  RAM write enable, active low
- o_writeData  out  16  RAM write data
- o_dataOe  out  1  enable for the write-data bus driver
- o_noe  out  1  RAM output-transmitter enable, active low
- i_readData  in  16  RAM read data

## Operation
- FSM states: IDLE, W_SETUP, W_PULSE, W_HOLD, READ. A down-counter loads on each state entry.
- IDLE: o_ready=1. On accept, latch i_addr/i_wdata into o_address/o_writeData. Go to W_SETUP if i_we=1, else READ.
- W_SETUP: o_dataOe=1, o_writeNEn=1. Stays SETUP_CYCLES cycles, then goes to W_PULSE.
- W_PULSE: o_dataOe=1, o_writeNEn=0. Stays PULSE_CYCLES cycles, then goes to W_HOLD.
- W_HOLD: o_dataOe=1, o_writeNEn=1. Stays HOLD_CYCLES cycles, then goes to IDLE with o_done=1 for one cycle.
- READ: o_noe=0, o_dataOe=0. Stays READ_CYCLES cycles. At the final edge, i_readData is captured into o_rdata; the FSM goes to IDLE with o_rvalid=1 for one cycle.
- o_address and o_writeData do not change outside IDLE accept; they hold after the transaction.
- Invariant: never o_dataOe=1 together with o_noe=0. Never o_writeNEn=0 while o_noe=0.
- i_req, i_we and i_addr are ignored outside IDLE.
- Back-to-back: a new accept is allowed in the same cycle o_done or o_rvalid is high.

## Timing
- All outputs are registered flops; no combinational path from inputs to bus outputs.
- Reset values:
  - State: IDLE.
  - o_ready=1 (combinational from the IDLE state register).
  - o_done=0, o_rvalid=0.
  - o_rdata=0, o_address=0, o_writeData=0.
  - o_writeNEn=1, o_dataOe=0, o_noe=1.
- Write latency: accept at edge 0. Bus is active for SETUP+PULSE+HOLD cycles. o_done is high in cycle SETUP+PULSE+HOLD+1. Defaults: strobe low in cycle 2, o_done in cycle 4.
- Read latency: accept at edge 0. o_noe is low for cycles 1..READ_CYCLES. o_rvalid is high in cycle READ_CYCLES+1. Defaults: o_rvalid in cycle 3.
- Reset mid-transaction: the next edge forces reset values. o_writeNEn and o_noe return high, and no o_done or o_rvalid is produced.
- Counter width is $clog2(max parameter)+1. Zero-valued parameters are illegal; an elaboration-time assertion catches them.

## Structure
- Package async_ram_pkg holds:
  - ADDR_W=16, DATA_W=16.
  - The enum type ram_master_state_t {IDLE, W_SETUP, W_PULSE, W_HOLD, READ}.
- Single module; the phase counter is inline. No sub-module is needed.
- The RAM model and its output transmitter are instantiated only in the testbench, on the bus side.

## Test plan
- Write 0x00A5←0x1234 with default parameters:
  - o_writeNEn low exactly in cycle 2, with address/data stable in cycles 1–3.
  - o_done in cycle 4.
  - RAM model holds 0x1234.
- Read 0x00A5 after that write:
  - o_noe low in cycles 1–2.
  - o_rvalid in cycle 3 with o_rdata=0x1234.
  - o_dataOe=0 throughout.
- Back-to-back write 0x0001←0xBEEF then read 0x0001, with i_req held high:
  - The second accept happens in the o_done cycle.
  - Read returns 0xBEEF.
  - The invariant checker never fires.
- Parameters SETUP=2, PULSE=3, HOLD=2, READ=4:
  - Strobe low in cycles 3–5.
  - o_done in cycle 8.
  - o_rvalid in cycle 5 of a read.
- Assert i_rst during W_PULSE:
  - Next cycle o_writeNEn=1, o_dataOe=0, o_ready=1.
  - No o_done.
  - Changing i_addr/i_req while busy has no effect on the bus.
